// File: rtl/gpio_irq_ctrl.sv
// GPIO edge-interrupt controller: synchronises pins, detects enabled edges into a W1C
// pending register and drives a level irq. Define GPIO_IRQ_DEBOUNCE_EN for per-pin debounce.
module gpio_irq_ctrl #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_RISE_EN = 3'd2,
    REG_FALL_EN = 3'd3,
    REG_LEVEL   = 3'd4
  } reg_addr_e;

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("gpio_irq_ctrl: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 1");
  end

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] enable_q, enable_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [31:0]      read_data_q, read_data_d;

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_set;
  reg_addr_e        reg_sel;
  logic             addr_ok;

  // Only address[4:2] and the low WIDTH data bits matter; the rest is folded here.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{address[31:5], address[1:0], write_data};

  assign wdata   = write_data[WIDTH-1:0];
  assign addr_ok = (address[4:2] <= 3'd4);
  assign reg_sel = reg_addr_e'(address[4:2]);

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign level_d = s2_q;
`endif

  assign edge_set = (~level_q & level_d & rise_en_q) | (level_q & ~level_d & fall_en_q);

  always_comb begin
    enable_d    = enable_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    pending_d   = pending_q;
    read_data_d = read_data_q;

    if (write) begin
      unique case (reg_sel)
        REG_PENDING: pending_d = pending_q & ~wdata;
        REG_ENABLE:  enable_d  = wdata;
        REG_RISE_EN: rise_en_d = wdata;
        REG_FALL_EN: fall_en_d = wdata;
        default:     ;
      endcase
    end
    // Applied after the W1C so a new event in the same cycle wins over the clear.
    pending_d = pending_d | edge_set;

    if (read) begin
      read_data_d = '0;
      if (addr_ok) begin
        unique case (reg_sel)
          REG_PENDING: read_data_d[WIDTH-1:0] = pending_q;
          REG_ENABLE:  read_data_d[WIDTH-1:0] = enable_q;
          REG_RISE_EN: read_data_d[WIDTH-1:0] = rise_en_q;
          REG_FALL_EN: read_data_d[WIDTH-1:0] = fall_en_q;
          REG_LEVEL:   read_data_d[WIDTH-1:0] = level_q;
          default:     ;
        endcase
      end
    end
  end

  // NOTE: async active-low reset clears every flop, and state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      level_q     <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      read_data_q <= '0;
    end else begin
      s1_q        <= gpio_in;
      s2_q        <= s1_q;
      level_q     <= level_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;
  assign irq       = |(pending_q & enable_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed self-checking bench for gpio_irq_ctrl; adapts level latency to GPIO_IRQ_DEBOUNCE_EN.
module tb_gpio_irq_ctrl;

  localparam int W   = 5;
  localparam int DEB = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int LAT = 1 + DEB;
`else
  localparam int LAT = 2;
`endif

  localparam logic [31:0] A_PENDING = 32'h00;
  localparam logic [31:0] A_ENABLE  = 32'h04;
  localparam logic [31:0] A_RISE_EN = 32'h08;
  localparam logic [31:0] A_FALL_EN = 32'h0C;
  localparam logic [31:0] A_LEVEL   = 32'h10;

  logic          clk;
  logic          reset;
  logic          read;
  logic          write;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic [W-1:0]  gpio_in;
  logic          irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;

  gpio_irq_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .gpio_in    (gpio_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (LAT + 1) step();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    address    = addr;
    write_data = data;
    write      = 1'b1;
    step();
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    address = addr;
    read    = 1'b1;
    step();
    read    = 1'b0;
    data    = read_data;
  endtask

  task automatic test_reset();
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    gpio_in = 5'h1F;
    repeat (3) step();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
    reset = 1'b1;
    repeat (LAT) step();
    bus_read(A_LEVEL, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_level_early got=%h exp=0", rd); end
    bus_read(A_LEVEL, rd);
    checks++; if (rd !== 32'h1F) begin failures++; $display("FAIL reset_level got=%h exp=1f", rd); end
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_after got=%b exp=0", irq); end
  endtask

  task automatic test_rising();
    gpio_in = 5'h1E;
    settle();
    bus_write(A_RISE_EN, 32'h01);
    bus_write(A_ENABLE, 32'h01);
    gpio_in = 5'h1F;
    repeat (LAT) step();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rise_irq_early got=%b exp=0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq got=%b exp=1", irq); end
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h01) begin failures++; $display("FAIL rise_pending got=%h exp=01", rd); end
    bus_write(A_PENDING, 32'h0);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rise_w0_noclear got=%b exp=1", irq); end
    bus_write(A_PENDING, 32'h01);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rise_w1c_irq got=%b exp=0", irq); end
  endtask

  task automatic test_falling_mask();
    bus_write(A_FALL_EN, 32'h10);
    bus_write(A_ENABLE, 32'h00);
    gpio_in = 5'h0F;
    settle();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_masked_irq got=%b exp=0", irq); end
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h10) begin failures++; $display("FAIL fall_pending got=%h exp=10", rd); end
    bus_write(A_ENABLE, 32'h10);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fall_unmask_irq got=%b exp=1", irq); end
    bus_write(A_PENDING, 32'h10);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_clear_irq got=%b exp=0", irq); end
  endtask

  task automatic test_collision();
    bus_write(A_RISE_EN, 32'h04);
    bus_write(A_ENABLE, 32'h04);
    gpio_in = 5'h0B;
    settle();
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL coll_fall_ignored got=%h exp=0", rd); end
    gpio_in = 5'h0F;
    settle();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL coll_first_rise got=%b exp=1", irq); end
    gpio_in = 5'h0B;
    settle();
    gpio_in = 5'h0F;
    repeat (LAT) step();
    bus_write(A_PENDING, 32'h04);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL coll_irq got=%b exp=1", irq); end
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h04) begin failures++; $display("FAIL coll_pending got=%h exp=04", rd); end
    bus_write(A_PENDING, 32'h04);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL coll_clear got=%b exp=0", irq); end
  endtask

  task automatic test_both_edges();
    bus_write(A_RISE_EN, 32'h02);
    bus_write(A_FALL_EN, 32'h02);
    bus_write(A_ENABLE, 32'h02);
    gpio_in = 5'h0D;
    settle();
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h02) begin failures++; $display("FAIL both_fall got=%h exp=02", rd); end
    bus_write(A_PENDING, 32'h02);
    gpio_in = 5'h0F;
    settle();
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h02) begin failures++; $display("FAIL both_rise got=%h exp=02", rd); end
    bus_write(A_PENDING, 32'h02);
    bus_write(A_RISE_EN, 32'h1F);
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL en_no_retro got=%h exp=0", rd); end
  endtask

  task automatic test_bus();
    address = A_ENABLE; write_data = 32'hFFFF_FFFF; read = 1'b1; write = 1'b1;
    step();
    read = 1'b0; write = 1'b0;
    checks++; if (read_data !== 32'h02) begin failures++; $display("FAIL rw_same_cycle got=%h exp=02", read_data); end
    bus_read(A_ENABLE, rd);
    checks++; if (rd !== 32'h1F) begin failures++; $display("FAIL enable_masked got=%h exp=1f", rd); end
    bus_read(32'h14, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL read_0x14 got=%h exp=0", rd); end
    bus_read(32'h1C, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL read_0x1c got=%h exp=0", rd); end
    bus_write(A_LEVEL, 32'h0);
    bus_read(A_LEVEL, rd);
    checks++; if (rd !== 32'h0F) begin failures++; $display("FAIL level_ro got=%h exp=0f", rd); end
    bus_write(A_ENABLE, 32'h0);
    bus_write(A_RISE_EN, 32'h0);
    bus_write(A_FALL_EN, 32'h0);
    repeat (3) step();
    checks++; if (read_data !== 32'h0F) begin failures++; $display("FAIL rdata_hold got=%h exp=0f", read_data); end
  endtask

  task automatic test_async_reset();
    bus_write(A_RISE_EN, 32'h08);
    bus_write(A_ENABLE, 32'h08);
    gpio_in = 5'h07;
    settle();
    gpio_in = 5'h0F;
    settle();
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL arst_pre_pending got=%h exp=08", rd); end
    #3 reset = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL arst_rdata got=%h exp=0", read_data); end
    step();
    reset = 1'b1;
    settle();
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL arst_pending got=%h exp=0", rd); end
    bus_read(A_ENABLE, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL arst_enable got=%h exp=0", rd); end
  endtask

  task automatic test_short_pulse();
    bus_write(A_RISE_EN, 32'h04);
    bus_write(A_ENABLE, 32'h04);
    gpio_in = 5'h0B;
    repeat (LAT + 3) step();
    bus_write(A_PENDING, 32'h1F);
`ifdef GPIO_IRQ_DEBOUNCE_EN
    gpio_in = 5'h0F;
    repeat (DEB - 1) step();
    gpio_in = 5'h0B;
    repeat (LAT + 3) step();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL deb_glitch_irq got=%b exp=0", irq); end
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL deb_glitch_pending got=%h exp=0", rd); end
    gpio_in = 5'h0F;
    repeat (LAT) step();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL deb_irq_early got=%b exp=0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL deb_irq got=%b exp=1", irq); end
    bus_read(A_LEVEL, rd);
    checks++; if (rd !== 32'h0F) begin failures++; $display("FAIL deb_level got=%h exp=0f", rd); end
`else
    gpio_in = 5'h0F;
    step();
    gpio_in = 5'h0B;
    repeat (LAT + 1) step();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pulse_irq got=%b exp=1", irq); end
    bus_read(A_PENDING, rd);
    checks++; if (rd !== 32'h04) begin failures++; $display("FAIL pulse_pending got=%h exp=04", rd); end
    bus_read(A_LEVEL, rd);
    checks++; if (rd !== 32'h0B) begin failures++; $display("FAIL pulse_level got=%h exp=0b", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling_mask();
    test_collision();
    test_both_edges();
    test_bus();
    test_async_reset();
    test_short_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
